// File: rtl/alu_seq_pipe.sv
// Handshaked WIDTH-bit ALU: single-cycle ops register in one cycle; MUL/MAC use an iterative shift-add engine.
// Optional feature macro: ALU_SAT_EN (signed saturation on op 000 ADD).
module alu_seq_pipe #(
    parameter int WIDTH    = 24,
    parameter int SHAMT_W  = $clog2(WIDTH),
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             lt,
    output logic             busy,
    output logic [1:0]       o_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // producers hold their payload stable while valid && !ready.

    localparam int N_STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W   = $clog2(N_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_MUL    = 3'b001;
    localparam logic [2:0] OP_PASS_B = 3'b010;
    localparam logic [2:0] OP_ADDR   = 3'b011;
    localparam logic [2:0] OP_OR     = 3'b100;
    localparam logic [2:0] OP_LUI    = 3'b101;
    localparam logic [2:0] OP_SRA    = 3'b110;
    localparam logic [2:0] OP_MAC    = 3'b111;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_addend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_z;
    logic             r_lt;
    logic             r_busy;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_lt_in;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_add_y;
    logic [WIDTH-1:0] w_sra;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_single_y;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_mul_y;

    assign in_ready  = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (op == OP_MUL) || (op == OP_MAC);
    assign w_lt_in   = $signed(a) < $signed(b);
    assign w_sum     = a + b;
    assign w_shamt   = b[SHAMT_W-1:0];
    // Arithmetic shift of a signed value fills with sign bits even for amounts >= WIDTH.
    assign w_sra     = WIDTH'($signed(a) >>> w_shamt);

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic w_ovf;
    assign w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_add_y = w_ovf ? (a[WIDTH-1] ? MIN_NEG : MAX_POS) : w_sum;
`else
    assign w_add_y = w_sum;
`endif

    always_comb begin
        w_single_y = '0;
        case (op)
            OP_ADD:            w_single_y = w_add_y;
            OP_ADDR:           w_single_y = w_sum;
            OP_OR:             w_single_y = a | b;
            OP_PASS_B, OP_LUI: w_single_y = b;
            OP_SRA:            w_single_y = w_sra;
            default:           w_single_y = '0;
        endcase
    end

    // One engine step: add the multiplicand shifted by each of the MUL_STEP low multiplier bits.
    always_comb begin
        w_partial = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (r_mplier[k]) begin
                w_partial = w_partial + (r_mcand << k);
            end
        end
    end

    assign w_mul_y = r_acc + w_partial + r_addend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_addend    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_z         <= 1'b0;
            r_lt        <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_lt <= w_lt_in;
                        if (w_is_mul) begin
                            r_state  <= S_MUL;
                            r_busy   <= 1'b1;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_addend <= (op == OP_MAC) ? c : '0;
                            r_cnt    <= '0;
                        end else begin
                            r_y         <= w_single_y;
                            r_z         <= (w_single_y == '0);
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= r_acc + w_partial;
                    r_mcand  <= r_mcand << MUL_STEP;
                    r_mplier <= r_mplier >> MUL_STEP;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_y         <= w_mul_y;
                        r_z         <= (w_mul_y == '0);
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign z         = r_z;
    assign lt        = r_lt;
    assign busy      = r_busy;
    assign o_state   = r_state;

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Self-checking bench for alu_seq_pipe (WIDTH=24, MUL_STEP=1): directed cases plus a randomized
// run scored against an arithmetic reference model through an expected-result queue.
module tb_alu_seq_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] c;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] y;
    logic        z;
    logic        lt;
    logic        busy;
    logic [1:0]  o_state;

    int checks   = 0;
    int failures = 0;

    // Expected result packed as {lt, z, y}.
    logic [25:0] exp_q[$];

    alu_seq_pipe #(.WIDTH(24), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .z(z), .lt(lt), .busy(busy), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] model(input logic [2:0] op_i, input logic [23:0] a_i,
                                          input logic [23:0] b_i, input logic [23:0] c_i);
        longint sa, sb, r;
        int sh;
        logic [23:0] ry;
        sa = longint'(a_i);
        sb = longint'(b_i);
        if (a_i[23]) sa = sa - 64'sd16777216;
        if (b_i[23]) sb = sb - 64'sd16777216;
        r = 0;
        case (op_i)
            3'd0: begin
                r = sa + sb;
`ifdef ALU_SAT_EN
                if (r > 64'sd8388607) r = 64'sd8388607;
                if (r < -64'sd8388608) r = -64'sd8388608;
`endif
            end
            3'd1: r = longint'(a_i) * longint'(b_i);
            3'd2, 3'd5: r = longint'(b_i);
            3'd3: r = longint'(a_i) + longint'(b_i);
            3'd4: r = longint'(a_i | b_i);
            3'd6: begin
                sh = int'(b_i[4:0]);
                if (sh >= 24) r = (sa < 0) ? -64'sd1 : 64'sd0;
                else          r = sa >>> sh;
            end
            default: r = longint'(c_i) + longint'(a_i) * longint'(b_i);
        endcase
        ry = 24'(r);
        return {(sa < sb), (ry == 24'd0), ry};
    endfunction

    // Monitor: pops one expected result per output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                check("result_y", 32'(y), 32'(e[23:0]));
                check("result_z", 32'(z), 32'(e[24]));
                check("result_lt", 32'(lt), 32'(e[25]));
            end
        end
    end

    task automatic send(input logic [2:0] op_i, input logic [23:0] a_i, input logic [23:0] b_i,
                        input logic [23:0] c_i, input logic [25:0] exp_i, input bit push);
        int waitc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; op = op_i; a = a_i; b = b_i; c = c_i;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        else if (push) exp_q.push_back(exp_i);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bcnt, saw;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_lt", 32'(lt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // ADD with one-cycle latency.
        out_ready = 1'b1;
        send(3'd0, 24'h000005, 24'h000003, 24'h0, {1'b0, 1'b0, 24'h000008}, 1'b1);
        @(negedge clk);
        check("add_latency", 32'(out_valid), 32'd1);

        // MUL -3 * 7: busy for 24 cycles, result at accept+25.
        send(3'd1, 24'hFFFFFD, 24'h000007, 24'h0, {1'b1, 1'b0, 24'hFFFFEB}, 1'b1);
        lat = 0; bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end while (!out_valid && lat < 60);
        check("mul_latency", 32'(lat), 32'd25);
        check("mul_busy_cycles", 32'(bcnt), 32'd24);
        check("mul_busy_end", 32'(busy), 32'd0);

        send(3'd7, 24'd4, 24'd5, 24'd10, {1'b0 | 1'b1, 1'b0, 24'h00001E}, 1'b1);
        wait_out();
        send(3'd6, 24'h800000, 24'd4, 24'h0, {1'b1, 1'b0, 24'hF80000}, 1'b1);
        wait_out();
        send(3'd6, 24'h800000, 24'd30, 24'h0, {1'b1, 1'b0, 24'hFFFFFF}, 1'b1);
        wait_out();
        send(3'd0, 24'hFFFFFF, 24'h000001, 24'h0, {1'b1, 1'b1, 24'h000000}, 1'b1);
        wait_out();
        send(3'd4, 24'h0F0000, 24'h0000F0, 24'h0, {1'b0, 1'b0, 24'h0F00F0}, 1'b1);
        wait_out();
        send(3'd5, 24'h123456, 24'hABC000, 24'h0, {1'b0, 1'b0, 24'hABC000}, 1'b1);
        wait_out();

        // Saturation boundaries; ADDR_ADD always wraps.
`ifdef ALU_SAT_EN
        send(3'd0, 24'h7FFFFF, 24'h000001, 24'h0, {1'b0, 1'b0, 24'h7FFFFF}, 1'b1);
        wait_out();
        send(3'd0, 24'h800000, 24'hFFFFFF, 24'h0, {1'b1, 1'b0, 24'h800000}, 1'b1);
        wait_out();
`else
        send(3'd0, 24'h7FFFFF, 24'h000001, 24'h0, {1'b0, 1'b0, 24'h800000}, 1'b1);
        wait_out();
        send(3'd0, 24'h800000, 24'hFFFFFF, 24'h0, {1'b1, 1'b0, 24'h7FFFFF}, 1'b1);
        wait_out();
`endif
        send(3'd3, 24'h7FFFFF, 24'h000001, 24'h0, {1'b0, 1'b0, 24'h800000}, 1'b1);
        wait_out();

        // Back-pressure: result held and input blocked, then released in the same cycle.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd0, 24'h000010, 24'h000020, 24'h0, {1'b1, 1'b0, 24'h000030}, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_y", 32'(y), 32'h30);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Reset in the middle of a multiply.
        send(3'd1, 24'd3, 24'd5, 24'h0, 26'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        check("abort_no_result", 32'(saw), 32'd0);
        send(3'd0, 24'd2, 24'd2, 24'h0, {1'b0, 1'b0, 24'h000004}, 1'b1);
        wait_out();

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 24'h7FFFFF;
                1: a = 24'h800000;
                2: a = 24'hFFFFFF;
                default: a = 24'($urandom);
            endcase
            b = (op == 3'd6 || $urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 31)) : 24'($urandom);
            c = 24'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back(model(op, a, b, c));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && (exp_q.size() != 0 || out_valid); n++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
